// File: rtl/kb_arbiter_if.sv
// Bundle of requester, control and key-checker signals around kb_arbiter.
// The master modport is the arbiter's view; slave is the environment's view.
interface kb_arbiter_if #(
  parameter int NREQ = 4
);
  localparam int IDW = $clog2(NREQ);

  logic                  stall;
  logic                  clr;
  logic [NREQ-1:0]       req;
  logic [NREQ*448-1:0]   req_kb;
  logic [127:0]          in_buf;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       rsp_valid;
  logic                  rsp_match;
  logic                  found;
  logic [IDW-1:0]        found_id;
  logic [447:0]          found_kb;
  logic                  tmo;
  logic                  chk_start;
  logic [447:0]          chk_kb;
  logic [127:0]          chk_in_buf;
  logic                  chk_done;
  logic                  chk_valid;

  modport master (
    input  stall, clr, req, req_kb, in_buf, chk_done, chk_valid,
    output gnt, rsp_valid, rsp_match, found, found_id, found_kb, tmo,
           chk_start, chk_kb, chk_in_buf
  );

  modport slave (
    output stall, clr, req, req_kb, in_buf, chk_done, chk_valid,
    input  gnt, rsp_valid, rsp_match, found, found_id, found_kb, tmo,
           chk_start, chk_kb, chk_in_buf
  );
endinterface

// File: rtl/kb_arbiter.sv
// Round-robin arbiter sharing one AES key-check unit among NREQ requesters.
// Optional WAIT timeout is enabled by defining KBARB_TIMEOUT_EN.
module kb_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 128
) (
  input  logic         clk,
  input  logic         rst,
  kb_arbiter_if.master bus
);
  localparam int IDW = $clog2(NREQ);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_RESP  = 3'd3;
  localparam logic [2:0] ST_HALT  = 3'd4;

  logic [2:0]      state_reg;
  logic [IDW-1:0]  ptr_reg;
  logic [IDW-1:0]  sel_reg;
  logic            wait_first_reg;
  logic            result_reg;
  logic            found_reg;
  logic [IDW-1:0]  found_id_reg;
  logic [447:0]    found_kb_reg;
  logic [447:0]    chk_kb_reg;
  logic [127:0]    chk_in_buf_reg;

`ifdef KBARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0]   wait_cnt_reg;
  logic            tmo_reg;
`endif

  logic [447:0]    kb_arr [NREQ];
  logic [NREQ-1:0] hi_req;
  logic [NREQ-1:0] sel_oh;
  logic [IDW-1:0]  sel_lo;
  logic [IDW-1:0]  sel_hi;
  logic [IDW-1:0]  sel_next;
  logic            busy;

  // hi_req keeps only requests at or above ptr so the scan wraps correctly.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign kb_arr[gi] = bus.req_kb[448*gi +: 448];
      assign hi_req[gi] = bus.req[gi] && (IDW'(gi) >= ptr_reg);
      assign sel_oh[gi] = (sel_reg == IDW'(gi));
    end
  endgenerate

  always_comb begin
    sel_lo = '0;
    sel_hi = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (bus.req[j]) sel_lo = IDW'(j);
      if (hi_req[j])  sel_hi = IDW'(j);
    end
  end

  assign sel_next = (|hi_req) ? sel_hi : sel_lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      ptr_reg        <= '0;
      sel_reg        <= '0;
      wait_first_reg <= 1'b0;
      result_reg     <= 1'b0;
      found_reg      <= 1'b0;
      found_id_reg   <= '0;
      found_kb_reg   <= '0;
      chk_kb_reg     <= '0;
      chk_in_buf_reg <= '0;
`ifdef KBARB_TIMEOUT_EN
      wait_cnt_reg   <= '0;
      tmo_reg        <= 1'b0;
`endif
    end else if (!bus.stall) begin
`ifdef KBARB_TIMEOUT_EN
      if (bus.clr) tmo_reg <= 1'b0;
`endif
      case (state_reg)
        ST_IDLE: begin
          if (|bus.req) begin
            sel_reg        <= sel_next;
            chk_kb_reg     <= kb_arr[sel_next];
            chk_in_buf_reg <= bus.in_buf;
            state_reg      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wait_first_reg <= 1'b1;
`ifdef KBARB_TIMEOUT_EN
          wait_cnt_reg   <= '0;
`endif
          state_reg      <= ST_WAIT;
        end
        ST_WAIT: begin
          // A done seen in the first WAIT cycle belongs to a previous check.
          wait_first_reg <= 1'b0;
          if (!wait_first_reg && bus.chk_done) begin
            result_reg <= bus.chk_valid;
            state_reg  <= ST_RESP;
          end
`ifdef KBARB_TIMEOUT_EN
          else if (wait_cnt_reg == CW'(TIMEOUT - 1)) begin
            result_reg <= 1'b0;
            tmo_reg    <= 1'b1;
            state_reg  <= ST_RESP;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
`endif
        end
        ST_RESP: begin
          ptr_reg <= (sel_reg == IDW'(NREQ - 1)) ? '0 : sel_reg + 1'b1;
          if (result_reg) begin
            found_reg    <= 1'b1;
            found_id_reg <= sel_reg;
            found_kb_reg <= chk_kb_reg;
            state_reg    <= ST_HALT;
          end else begin
            state_reg    <= ST_IDLE;
          end
        end
        ST_HALT: begin
          if (bus.clr) begin
            found_reg <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode registered state only, so a stall holds them naturally.
  assign busy          = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT) ||
                         (state_reg == ST_RESP);
  assign bus.gnt       = busy ? sel_oh : '0;
  assign bus.rsp_valid = (state_reg == ST_RESP) ? sel_oh : '0;
  assign bus.rsp_match = (state_reg == ST_RESP) && result_reg;
  assign bus.chk_start = (state_reg == ST_ISSUE);
  assign bus.chk_kb    = chk_kb_reg;
  assign bus.chk_in_buf = chk_in_buf_reg;
  assign bus.found     = found_reg;
  assign bus.found_id  = found_id_reg;
  assign bus.found_kb  = found_kb_reg;
`ifdef KBARB_TIMEOUT_EN
  assign bus.tmo       = tmo_reg;
`else
  assign bus.tmo       = 1'b0;
`endif
endmodule
